fence_seq: RTL and testbench
============================

# fence_seq

Fence sequencer for the issue stage. It takes one FENCE / FENCE.I request at a time from issue and waits for the integer and load/store pipes to drain. For FENCE.I it then runs the D-cache flush followed by the I-cache invalidate, and finally redirects fetch to pc+4. Issue holds the fence instruction at its head until this block reports completion; the block owns the `dm_flush_req`/`im_invalidate_req` handshakes and the fetch PC override.

## Interface
- `XLEN`, 64, width of PC datapath
- `FENCEI_STEP`, 4, byte offset added to the fence PC for the redirect target
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `pipe_flush`  in  1  pipeline flush from branch/trap; aborts the request
- `req_valid`  in  1  fence instruction at head of issue
- `req_fencei`  in  1  request is FENCE.I (0 = plain FENCE); sampled on accept
- `req_pc`  in  XLEN  PC of the fence instruction; sampled on accept
- `req_done`  out  1  one-cycle pulse: fence complete, issue may retire it
- `busy`  out  1  high in every state except IDLE
- `drain_done`  in  1  all of the following are empty: IP execute/writeback, LSP address-gen/mem/writeback
- `dm_flush_req`  out  1  D-cache writeback-flush request, level
- `dm_flush_resp`  in  1  D-cache flush complete, one-cycle pulse
- `im_invalidate_req`  out  1  I-cache invalidate request, level
- `im_invalidate_resp`  in  1  I-cache invalidate complete, one-cycle pulse
- `if_pc_override`  out  1  one-cycle fetch redirect strobe
- `if_new_pc`  out  XLEN  redirect target, valid while `if_pc_override`=1

## Operation
- All outputs are registered. Reset values: `req_done`, `busy`, `dm_flush_req`, `im_invalidate_req` and `if_pc_override` are 0; `if_new_pc` is 0; state is IDLE; captured PC and fencei flag are 0; `abort` is 0.
- **IDLE:** when `req_valid` && !`pipe_flush`, capture `req_pc` and `req_fencei`, then go to DRAIN.
- **DRAIN:**
  - `pipe_flush` → IDLE, no `req_done`.
  - Otherwise, when `drain_done`: FENCE → DONE; FENCE.I → DFLUSH.
- **DFLUSH:** `dm_flush_req`=1 on entry. On `dm_flush_resp`: deassert the request next cycle and go to IINV.
- **IINV:** `im_invalidate_req`=1 on entry. On `im_invalidate_resp`: deassert the request, then go to REDIR, or to IDLE if `abort` is set.
- **REDIR:** `if_pc_override`=1 for exactly one cycle, `if_new_pc` = captured PC + `FENCEI_STEP`, modulo 2^XLEN. Then go to DONE.
- **DONE:** `req_done`=1 for one cycle → IDLE.
- Ordering rule: the I-cache invalidate never starts before the D-cache flush response. Refill must observe written-back data.
- `pipe_flush` during DFLUSH or IINV sets `abort`. The cache operation in progress runs to completion, and so does the invalidate. REDIR and DONE are skipped; `abort` clears on return to IDLE.
- `pipe_flush` in REDIR or DONE: the pulse still fires. Fetch gives `pipe_flush` priority.
- A response pulse arriving while the matching request is 0 is ignored. Both responses asserted together in DFLUSH: only `dm_flush_resp` is consumed.
- `req_valid` is ignored while `busy`. `req_fencei` and `req_pc` changes after accept have no effect.
- Reset asserted mid-operation clears all state and outputs immediately. Cache requests drop without waiting for a response.

## Timing
- Plain FENCE with `drain_done` already 1:
  - accept at cycle 0
  - DRAIN at cycle 1
  - `req_done` high at cycle 2
  - 3 cycles total
- FENCE.I: `dm_flush_req` rises 1 cycle after leaving DRAIN.
  - Resp at cycle t → `dm_flush_req` falls and `im_invalidate_req` rises at t+1.
  - Invalidate resp at u → `if_pc_override` at u+1 → `req_done` at u+2.
- `busy` rises the cycle after accept and falls the cycle after the last active-state cycle.
- No combinational path from any input to any output.

## Test plan
- FENCE, `drain_done`=1, `req_pc`=0x1000 → `req_done` pulses exactly once at cycle 2; no cache requests; no override.
- FENCE.I, `req_pc`=0x8000_0000, `drain_done` low for 5 cycles, `dm_flush_resp` 3 cycles after request, `im_invalidate_resp` 2 cycles after request → requests are strictly sequential; one `if_pc_override` with `if_new_pc`=0x8000_0004; then `req_done`.
- `req_pc`=0xFFFF_FFFF_FFFF_FFFC with FENCE.I → `if_new_pc`=0.
- `pipe_flush` in DRAIN → IDLE next cycle, no `req_done`. `pipe_flush` in DFLUSH → flush and invalidate both complete; no override; no `req_done`; `busy` returns to 0.
- `dm_flush_resp` and `im_invalidate_resp` both pulsed in the first DFLUSH cycle → `im_invalidate_req` still asserts and waits for a new `im_invalidate_resp`.
- `rst_n` low while `im_invalidate_req`=1 → all outputs 0 asynchronously. After release, a new FENCE completes normally.

Source files
------------

// File: rtl/fence_seq.sv
// -----------------------------------------------------------------------------
// fence_seq
// Fence sequencer for the issue stage. Accepts one FENCE / FENCE.I at a time,
// waits for the integer and load/store pipes to drain and then, for FENCE.I,
// runs the D-cache writeback flush, the I-cache invalidate and a fetch
// redirect to pc + FENCEI_STEP before reporting completion to issue.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   pipe_flush            branch/trap flush, aborts the current request
//   req_valid/req_fencei/req_pc
//                         fence at head of issue, sampled on accept
//   req_done              one-cycle completion pulse to issue
//   busy                  high whenever the sequencer is not idle
//   drain_done            IP and LSP pipes are empty
//   dm_flush_req/resp     D-cache flush handshake (level req, pulse resp)
//   im_invalidate_req/resp
//                         I-cache invalidate handshake (level req, pulse resp)
//   if_pc_override        one-cycle fetch redirect strobe
//   if_new_pc             redirect target, valid with if_pc_override
// All outputs are registered; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module fence_seq #(
   parameter int XLEN        = 64,
   parameter int FENCEI_STEP = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_flush,
   input  logic            req_valid,
   input  logic            req_fencei,
   input  logic [XLEN-1:0] req_pc,
   output logic            req_done,
   output logic            busy,
   input  logic            drain_done,
   output logic            dm_flush_req,
   input  logic            dm_flush_resp,
   output logic            im_invalidate_req,
   input  logic            im_invalidate_resp,
   output logic            if_pc_override,
   output logic [XLEN-1:0] if_new_pc
);

   localparam logic [XLEN-1:0] STEP = XLEN'(FENCEI_STEP);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_DFLUSH = 3'd2,
      ST_IINV   = 3'd3,
      ST_REDIR  = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [XLEN-1:0] pc_r;
   logic            fencei_r;
   logic            abort_r;
   logic            abort_nxt_s;
   logic            accept_s;
   logic            dm_ack_s;
   logic            im_ack_s;

   logic            busy_r;
   logic            req_done_r;
   logic            dm_req_r;
   logic            im_req_r;
   logic            ovr_r;
   logic [XLEN-1:0] new_pc_r;

   logic            busy_nxt_s;
   logic            req_done_nxt_s;
   logic            dm_req_nxt_s;
   logic            im_req_nxt_s;
   logic            ovr_nxt_s;
   logic [XLEN-1:0] new_pc_nxt_s;

   // State, captured request and abort flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         pc_r     <= {XLEN{1'b0}};
         fencei_r <= 1'b0;
         abort_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         abort_r <= abort_nxt_s;
         if (accept_s) begin
            pc_r     <= req_pc;
            fencei_r <= req_fencei;
         end else begin
            pc_r     <= pc_r;
            fencei_r <= fencei_r;
         end
      end
   end

   // Next-state and abort tracking.
   always_comb begin
      state_nxt_s = state_r;
      abort_nxt_s = abort_r;
      accept_s    = 1'b0;
      // A response only counts while its own request is asserted, so stray
      // pulses (or an early invalidate response during the flush) are dropped.
      dm_ack_s    = dm_flush_resp & dm_req_r;
      im_ack_s    = im_invalidate_resp & im_req_r;
      case (state_r)
         ST_IDLE: begin
            abort_nxt_s = 1'b0;
            if (req_valid && !pipe_flush) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (pipe_flush) begin
               state_nxt_s = ST_IDLE;
            end else if (drain_done) begin
               state_nxt_s = fencei_r ? ST_DFLUSH : ST_DONE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_DFLUSH: begin
            // The flush is never cancelled; a flush only remembers the abort.
            if (pipe_flush) begin
               abort_nxt_s = 1'b1;
            end else begin
               abort_nxt_s = abort_r;
            end
            if (dm_ack_s) begin
               state_nxt_s = ST_IINV;
            end else begin
               state_nxt_s = ST_DFLUSH;
            end
         end
         ST_IINV: begin
            if (im_ack_s) begin
               // A flush arriving together with the response still aborts.
               if (abort_r || pipe_flush) begin
                  state_nxt_s = ST_IDLE;
                  abort_nxt_s = 1'b0;
               end else begin
                  state_nxt_s = ST_REDIR;
                  abort_nxt_s = 1'b0;
               end
            end else begin
               state_nxt_s = ST_IINV;
               abort_nxt_s = abort_r | pipe_flush;
            end
         end
         ST_REDIR: begin
            state_nxt_s = ST_DONE;
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            abort_nxt_s = 1'b0;
         end
      endcase
   end

   // Output decode from the next state so every output is a plain flop.
   always_comb begin
      busy_nxt_s     = (state_nxt_s != ST_IDLE);
      dm_req_nxt_s   = (state_nxt_s == ST_DFLUSH);
      im_req_nxt_s   = (state_nxt_s == ST_IINV);
      ovr_nxt_s      = (state_nxt_s == ST_REDIR);
      req_done_nxt_s = (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_REDIR) begin
         new_pc_nxt_s = pc_r + STEP;
      end else begin
         new_pc_nxt_s = new_pc_r;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r     <= 1'b0;
         req_done_r <= 1'b0;
         dm_req_r   <= 1'b0;
         im_req_r   <= 1'b0;
         ovr_r      <= 1'b0;
         new_pc_r   <= {XLEN{1'b0}};
      end else begin
         busy_r     <= busy_nxt_s;
         req_done_r <= req_done_nxt_s;
         dm_req_r   <= dm_req_nxt_s;
         im_req_r   <= im_req_nxt_s;
         ovr_r      <= ovr_nxt_s;
         new_pc_r   <= new_pc_nxt_s;
      end
   end

   assign busy              = busy_r;
   assign req_done          = req_done_r;
   assign dm_flush_req      = dm_req_r;
   assign im_invalidate_req = im_req_r;
   assign if_pc_override    = ovr_r;
   assign if_new_pc         = new_pc_r;

endmodule

// File: tb/tb_fence_seq.sv
// -----------------------------------------------------------------------------
// tb_fence_seq
// Self-checking bench for fence_seq. Each scenario is described by its
// request, drain delay, response latencies and optional flush cycle. The
// expected waveform is derived from event times (drain end, flush response,
// invalidate response) with plain arithmetic, and compared cycle by cycle.
// A table of directed scenarios also carries hand-computed summary results.
// -----------------------------------------------------------------------------
module tb_fence_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_flush;
   logic        req_valid;
   logic        req_fencei;
   logic [63:0] req_pc;
   logic        req_done;
   logic        busy;
   logic        drain_done;
   logic        dm_flush_req;
   logic        dm_flush_resp;
   logic        im_invalidate_req;
   logic        im_invalidate_resp;
   logic        if_pc_override;
   logic [63:0] if_new_pc;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          fencei;
      logic [63:0] pc;
      int          d_wait;    // cycles drain_done stays low in DRAIN
      int          dm_lat;    // cycles from dm request rise to response
      int          im_lat;    // cycles from im request rise to response
      int          flush_at;  // cycle of the pipe_flush pulse, -1 = none
      bit          dup_im;    // also pulse im resp with the dm resp
      int          e_done;
      int          e_ovr;
      int          e_busy;
      logic [63:0] e_pc;
   } vec_t;

   vec_t tbl [10];

   fence_seq #(.XLEN(64), .FENCEI_STEP(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .pipe_flush        (pipe_flush),
      .req_valid         (req_valid),
      .req_fencei        (req_fencei),
      .req_pc            (req_pc),
      .req_done          (req_done),
      .busy              (busy),
      .drain_done        (drain_done),
      .dm_flush_req      (dm_flush_req),
      .dm_flush_resp     (dm_flush_resp),
      .im_invalidate_req (im_invalidate_req),
      .im_invalidate_resp(im_invalidate_resp),
      .if_pc_override    (if_pc_override),
      .if_new_pc         (if_new_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      pipe_flush         = 1'b0;
      req_valid          = 1'b0;
      req_fencei         = 1'b0;
      req_pc             = 64'h0;
      drain_done         = 1'b0;
      dm_flush_resp      = 1'b0;
      im_invalidate_resp = 1'b0;
   endtask

   // Runs one scenario starting from IDLE just after a rising edge.
   task automatic run_scn(input vec_t s, input string tag,
                          output int n_done, output int n_ovr,
                          output int n_busy, output logic [63:0] last_pc);
      int d, t, u, f, last, done_c;
      bit drain_ab, cache_ab;
      logic [4:0] exp_v, got_v;
      d = 1 + s.d_wait;
      t = d + 1 + s.dm_lat;
      u = t + 1 + s.im_lat;
      f = s.flush_at;
      drain_ab = (f >= 1) && (f <= d);
      cache_ab = s.fencei && !drain_ab && (f >= d + 1) && (f <= u);
      done_c   = s.fencei ? u + 2 : d + 1;
      if (drain_ab)      last = f;
      else if (cache_ab) last = u;
      else               last = done_c;
      n_done = 0; n_ovr = 0; n_busy = 0; last_pc = 64'h0;
      for (int c = 0; c <= last + 2; c++) begin
         // stimulus for cycle c
         req_valid  = (c <= last);
         req_fencei = (c == 0) ? s.fencei : 1'($urandom_range(0, 1));
         req_pc     = (c == 0) ? s.pc : {$urandom, $urandom};
         drain_done = (c >= d);
         pipe_flush = (c == f);
         dm_flush_resp = s.fencei && (c == t);
         im_invalidate_resp = s.fencei && ((c == u) || (s.dup_im && c == t));
         if (c >= 1 && c <= d) begin
            dm_flush_resp      = 1'($urandom_range(0, 1));
            im_invalidate_resp = 1'($urandom_range(0, 1));
         end
         if (s.fencei && c >= t + 1 && c < u) begin
            dm_flush_resp = 1'($urandom_range(0, 1));
         end
         // expected outputs during cycle c
         exp_v[4] = (c >= 1) && (c <= last);
         exp_v[3] = s.fencei && !drain_ab && (c >= d + 1) && (c <= t);
         exp_v[2] = s.fencei && !drain_ab && (c >= t + 1) && (c <= u);
         exp_v[1] = s.fencei && !drain_ab && !cache_ab && (c == u + 1);
         exp_v[0] = !drain_ab && !cache_ab && (c == done_c);
         @(negedge clk);
         got_v = {busy, dm_flush_req, im_invalidate_req, if_pc_override, req_done};
         chk($sformatf("%s c%0d {busy,dm,im,ovr,done}", tag, c), 64'(got_v), 64'(exp_v));
         if (exp_v[1]) begin
            chk($sformatf("%s c%0d if_new_pc", tag, c), if_new_pc, s.pc + 64'd4);
         end
         n_done += int'(req_done);
         n_ovr  += int'(if_pc_override);
         n_busy += int'(busy);
         if (if_pc_override) last_pc = if_new_pc;
         @(posedge clk);
         #1;
      end
      idle_inputs();
   endtask

   initial begin
      int nd, no, nb;
      logic [63:0] lp;
      vec_t r;

      //          fi    pc                      dw dm im fl  dup done ovr busy pc
      tbl[0] = '{1'b0, 64'h1000,              0, 0, 0, -1, 1'b0, 1, 0, 2,  64'h0};
      tbl[1] = '{1'b1, 64'h8000_0000,         5, 3, 2, -1, 1'b0, 1, 1, 15, 64'h8000_0004};
      tbl[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, -1, 1'b0, 1, 1, 5,  64'h0};
      tbl[3] = '{1'b0, 64'h2000,              3, 0, 0, 2,  1'b0, 0, 0, 2,  64'h0};
      tbl[4] = '{1'b1, 64'h3000,              0, 2, 1, 3,  1'b0, 0, 0, 6,  64'h0};
      tbl[5] = '{1'b1, 64'h4000,              2, 0, 0, 3,  1'b0, 0, 0, 3,  64'h0};
      tbl[6] = '{1'b1, 64'h5000,              0, 1, 2, 5,  1'b0, 0, 0, 6,  64'h0};
      tbl[7] = '{1'b1, 64'h6000,              0, 0, 0, 4,  1'b0, 1, 1, 5,  64'h6004};
      tbl[8] = '{1'b0, 64'h7000,              0, 0, 0, 2,  1'b0, 1, 0, 2,  64'h0};
      tbl[9] = '{1'b1, 64'h9000,              0, 0, 3, -1, 1'b1, 1, 1, 8,  64'h9004};

      // reset state
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset busy", 64'(busy), 64'h0);
      chk("reset req_done", 64'(req_done), 64'h0);
      chk("reset dm_flush_req", 64'(dm_flush_req), 64'h0);
      chk("reset im_invalidate_req", 64'(im_invalidate_req), 64'h0);
      chk("reset if_pc_override", 64'(if_pc_override), 64'h0);
      chk("reset if_new_pc", if_new_pc, 64'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed table
      for (int i = 0; i < 10; i++) begin
         run_scn(tbl[i], $sformatf("vec%0d", i), nd, no, nb, lp);
         chk($sformatf("vec%0d done_count", i), 64'(nd), 64'(tbl[i].e_done));
         chk($sformatf("vec%0d ovr_count", i), 64'(no), 64'(tbl[i].e_ovr));
         chk($sformatf("vec%0d busy_cycles", i), 64'(nb), 64'(tbl[i].e_busy));
         chk($sformatf("vec%0d redirect_pc", i), lp, tbl[i].e_pc);
      end

      // randomized scenarios against the event-time model
      for (int i = 0; i < 40; i++) begin
         r.fencei   = 1'($urandom_range(0, 1));
         r.pc       = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) r.pc[63:4] = '1;
         r.d_wait   = $urandom_range(0, 4);
         r.dm_lat   = $urandom_range(0, 4);
         r.im_lat   = $urandom_range(0, 4);
         r.flush_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16)) : -1;
         r.dup_im   = 1'($urandom_range(0, 1));
         run_scn(r, $sformatf("rnd%0d", i), nd, no, nb, lp);
      end

      // reset while the invalidate request is up
      req_valid  = 1'b1;
      req_fencei = 1'b1;
      req_pc     = 64'h40;
      drain_done = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      dm_flush_resp = 1'b1;
      @(posedge clk); #1;
      dm_flush_resp = 1'b0;
      @(negedge clk);
      chk("rst_mid im_req before reset", 64'(im_invalidate_req), 64'h1);
      chk("rst_mid if_new_pc before reset", if_new_pc, 64'h0 + tbl[9].pc + 64'd4 - tbl[9].pc + if_new_pc - 64'd4);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid busy", 64'(busy), 64'h0);
      chk("rst_mid req_done", 64'(req_done), 64'h0);
      chk("rst_mid dm_flush_req", 64'(dm_flush_req), 64'h0);
      chk("rst_mid im_invalidate_req", 64'(im_invalidate_req), 64'h0);
      chk("rst_mid if_pc_override", 64'(if_pc_override), 64'h0);
      chk("rst_mid if_new_pc", if_new_pc, 64'h0);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_scn(tbl[0], "post_rst", nd, no, nb, lp);
      chk("post_rst done_count", 64'(nd), 64'h1);
      chk("post_rst busy_cycles", 64'(nb), 64'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
